hilo_div_ctrl: RTL



---
 rtl/mips_hilo_pkg.sv | 16 +
 rtl/hilo_div_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/mips_hilo_pkg.sv
// Shared encodings for the HI/LO divide sequencer: op codes, FSM states, default settle time.
package mips_hilo_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_MTHI = 2'b01;
    localparam logic [1:0] OP_MTLO = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam int DIV_CYCLES_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/hilo_div_ctrl.sv
// HI/LO sequencer around an external combinational divider; also services MTHI/MTLO.
// Optional macro HILO_BYPASS_EN makes hi/lo show their next value combinationally.
module hilo_div_ctrl
    import mips_hilo_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] S,
    input  logic [31:0] T,
    input  logic [31:0] quot_in,
    input  logic [31:0] rem_in,
    output logic [31:0] div_s,
    output logic [31:0] div_t,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [31:0]        div_s_n, div_t_n;
    logic [31:0]        hi_q, hi_n, lo_q, lo_n;
    logic               done_n, dz_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            div_s <= '0;
            div_t <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            div_s <= div_s_n;
            div_t <= div_t_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            done  <= done_n;
            dz    <= dz_n;
        end
    end

    // Commands are only accepted in IDLE; anything issued during RUN is dropped.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_s_n = div_s;
        div_t_n = div_t;
        hi_n    = hi_q;
        lo_n    = lo_q;
        done_n  = 1'b0;
        dz_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_DIV: begin
                            if (T != '0) begin
                                state_n = ST_RUN;
                                div_s_n = S;
                                div_t_n = T;
                                cnt_n   = CNT_W'(DIV_CYCLES - 1);
                            end else begin
                                dz_n = 1'b1;
                            end
                        end
                        OP_MTHI: hi_n = S;
                        OP_MTLO: lo_n = S;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    hi_n    = rem_in;
                    lo_n    = quot_in;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);

`ifdef HILO_BYPASS_EN
    // The next-state values already equal the registers except on a write cycle.
    assign hi = hi_n;
    assign lo = lo_n;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule
